mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single byte-enabled 32-bit memory port between the CPU instruction-fetch port (read-only) and data port (read/write).
// - Sits between the MIPS core and the memory: one access in flight, registered responses, fixed data priority with an instruction anti-starvation override.
// - Inserts WAIT_CYCLES stall cycles per access so the core is exercised against slower memory timing.
// PARAMETERS
// - WAIT_CYCLES  default 0  extra memory-busy cycles per access (0..15)
// - STARVE_MAX   default 4  consecutive data wins while i_req pending before instruction port is forced to win (1..15)
// PORTS
// - clk            in   1   clock, all state on rising edge
// - rst_n          in   1   asynchronous active-low reset
// - i_req          in   1   instruction read request; held until i_gnt
// - i_addr         in   32  instruction byte address
// - i_gnt          out  1   instruction request accepted this cycle
// - i_rvalid       out  1   one-cycle pulse: i_rdata valid
// - i_rdata        out  32  instruction word read
// - d_req          in   1   data request; held until d_gnt
// - d_we           in   1   1 = write, 0 = read
// - d_byte_en      in   4   byte lanes for writes, bit n = writedata[8n+7:8n]
// - d_addr         in   32  data byte address
// - d_wdata        in   32  write data
// - d_gnt          out  1   data request accepted this cycle
// - d_rvalid       out  1   one-cycle pulse: data read complete or write done
// - d_rdata        out  32  data word read
// - mem_address    out  32  to memory address
// - mem_write      out  1   to memory write
// - mem_byte_en    out  4   to memory byte_en
// - mem_writedata  out  32  to memory writedata
// - mem_readdata   in   32  from memory readdata (combinational path)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, wait counter 0, starve counter 0; async assertion kills any in-flight access (no write issued).
// - FSM IDLE -> BUSY -> RESP:
//   IDLE: no req -> stay; req -> gnt (combinational, same cycle), latch addr/we/be/wdata/port id, -> BUSY.
//   BUSY: lasts WAIT_CYCLES+1 cycles; mem_* driven from latched regs; final cycle: mem_write=latched we, readdata captured -> RESP.
//   RESP: pulse rvalid of owning port; may grant next request in this same cycle (-> BUSY), else -> IDLE.
// - Latency, WAIT_CYCLES=0: gnt cycle T, memory access T+1, rvalid T+2; add WAIT_CYCLES to access/rvalid.
// - mem_write high exactly one cycle per write, only in the final BUSY cycle; mem_byte_en = latched d_byte_en for writes, 4'hF for reads, 0 when not BUSY.
// - mem_address: instruction access forces low 2 bits to 00; data address passed unchanged; holds last value outside BUSY.
// - Writes: d_rvalid pulses as completion, d_rdata unchanged. Reads: rdata reg of owning port only updates.
// - Arbitration (IDLE or RESP): both req -> data wins unless starve count == STARVE_MAX, then instruction wins.
// - Starve counter: +1 per data grant while i_req high and not granted; cleared on i_gnt; saturates at STARVE_MAX.
// - i_gnt and d_gnt never high together; no grant while BUSY.
// - Request dropped before gnt: nothing recorded. Inputs changing after gnt: ignored.
// STRUCTURE
// - Package mem_arb_pkg: state enum (IDLE, BUSY, RESP), port-id enum (PORT_I, PORT_D), WAIT/STARVE counter widths.
// - Sub-module mem_arb_pick: combinational winner select from i_req, d_req, starve count; counter kept in top.
// TESTING
// - Reset, no req -> all outputs 0 and mem_write never asserts for 20 cycles.
// - i_req, i_addr=0x0000_0106, mem holds 0xDEADBEEF at 0x104 -> mem_address=0x104 at T+1, i_rvalid + i_rdata=0xDEADBEEF at T+2.
// - d write addr 0x200, be=4'b0101, wdata=0x11223344 over 0xAABBCCDD -> exactly one mem_write pulse; readback 0xAA22CC44.
// - i_req and d_req held high, STARVE_MAX=4 -> grant order D,D,D,D,I repeating; gnts never overlap.
// - WAIT_CYCLES=3, d read -> d_rvalid exactly 5 cycles after d_gnt; next grant in RESP cycle.
// - rst_n low in final BUSY cycle of a write -> memory unchanged, all outputs 0, IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, port ids, counter widths
// and the packed record of one latched access.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam int WAIT_W   = 4;
    localparam int STARVE_W = 4;

    typedef struct packed {
        port_t       port;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between instruction and data requests.
// Latency: combinational.
// Backpressure: none; the caller gates the result with its own grant window.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                pick_i,
    output logic                pick_d
);

    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (i_req && d_req) begin
            // Data normally wins; instruction fetch forced through once starved.
            if (starve_cnt == STARVE_W'(STARVE_MAX))
                pick_i = 1'b1;
            else
                pick_d = 1'b1;
        end else begin
            pick_i = i_req;
            pick_d = d_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-enabled 32-bit memory port between instruction and data ports.
// Latency: grant at T, memory access at T+1+WAIT_CYCLES, rvalid at T+2+WAIT_CYCLES.
// Backpressure: one access in flight; requests hold until their gnt, none granted while BUSY.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_byte_en,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    state_t              state;
    req_t                lat;
    req_t                next_req;
    logic [WAIT_W-1:0]   wcnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                pick_i;
    logic                pick_d;
    logic                can_grant;
    logic                busy_last;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .pick_i     (pick_i),
        .pick_d     (pick_d)
    );

    assign can_grant = (state == IDLE) || (state == RESP);
    assign i_gnt     = can_grant && pick_i;
    assign d_gnt     = can_grant && pick_d;
    assign busy_last = (state == BUSY) && (wcnt == WAIT_W'(WAIT_CYCLES));

    // Memory side is driven straight from the latched access, so it drops
    // immediately when reset kills an in-flight write.
    assign mem_address   = lat.addr;
    assign mem_writedata = lat.wdata;
    assign mem_write     = busy_last && lat.we;
    assign mem_byte_en   = (state == BUSY) ? lat.be : 4'h0;

    always_comb begin
        next_req = '0;
        if (pick_i) begin
            next_req.port = PORT_I;
            next_req.we   = 1'b0;
            next_req.be   = 4'hF;
            next_req.addr = i_addr & 32'hFFFF_FFFC;
        end else begin
            next_req.port  = PORT_D;
            next_req.we    = d_we;
            next_req.be    = d_we ? d_byte_en : 4'hF;
            next_req.addr  = d_addr;
            next_req.wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat        <= '0;
            wcnt       <= '0;
            starve_cnt <= '0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            case (state)
                IDLE, RESP: begin
                    if (i_gnt || d_gnt) begin
                        lat   <= next_req;
                        wcnt  <= '0;
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (busy_last) begin
                        state <= RESP;
                        if (lat.port == PORT_I) begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_readdata;
                        end else begin
                            d_rvalid <= 1'b1;
                            if (!lat.we)
                                d_rdata <= mem_readdata;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Counts data wins that overtook a waiting fetch.
            if (i_gnt)
                starve_cnt <= '0;
            else if (d_gnt && i_req && (starve_cnt != STARVE_W'(STARVE_MAX)))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-schedule model checked every cycle on the
// WAIT_CYCLES=0 instance, plus directed literal checks including a WAIT_CYCLES=3 instance.
module tb_mem_port_arbiter;

    localparam int W0   = 0;
    localparam int W3   = 3;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // shared data-side inputs
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] i_addr, d_addr, d_wdata;

    // instance 0 (WAIT_CYCLES=0)
    logic        i_req0, d_req0;
    logic        i_gnt0, i_rvalid0, d_gnt0, d_rvalid0, mem_wr0;
    logic [31:0] i_rdata0, d_rdata0, mem_addr0, mem_wd0, mem_rd0;
    logic [3:0]  mem_be0;

    // instance 3 (WAIT_CYCLES=3)
    logic        i_req3, d_req3;
    logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, mem_wr3;
    logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wd3, mem_rd3;
    logic [3:0]  mem_be3;

    mem_port_arbiter #(.WAIT_CYCLES(W0), .STARVE_MAX(SMAX)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req0), .i_addr(i_addr), .i_gnt(i_gnt0), .i_rvalid(i_rvalid0), .i_rdata(i_rdata0),
        .d_req(d_req0), .d_we(d_we), .d_byte_en(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
        .mem_address(mem_addr0), .mem_write(mem_wr0), .mem_byte_en(mem_be0),
        .mem_writedata(mem_wd0), .mem_readdata(mem_rd0)
    );

    mem_port_arbiter #(.WAIT_CYCLES(W3), .STARVE_MAX(SMAX)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req3), .i_addr(i_addr), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_we(d_we), .d_byte_en(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_address(mem_addr3), .mem_write(mem_wr3), .mem_byte_en(mem_be3),
        .mem_writedata(mem_wd3), .mem_readdata(mem_rd3)
    );

    // memories behind each instance; preloaded on the first clock edge
    logic [31:0] mem0 [256];
    logic [31:0] mem3 [256];
    int          wr_pulses0 = 0;

    assign mem_rd0 = mem0[mem_addr0[9:2]];
    assign mem_rd3 = mem3[mem_addr3[9:2]];

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 32'h0;
                mem3[i] <= 32'h0;
            end
            mem0[65]  <= 32'hDEAD_BEEF;
            mem0[128] <= 32'hAABB_CCDD;
            mem3[192] <= 32'h1234_5678;
        end else begin
            if (mem_wr0) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be0[b]) mem0[mem_addr0[9:2]][8*b +: 8] <= mem_wd0[8*b +: 8];
                wr_pulses0 <= wr_pulses0 + 1;
            end
            if (mem_wr3) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be3[b]) mem3[mem_addr3[9:2]][8*b +: 8] <= mem_wd3[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each grant at cycle g schedules the access window [g+1, g+1+W]
    // and the response at g+2+W; the port is free again at g+2+W.
    logic        ref_loaded = 1'b0;
    logic [31:0] refm [256];
    logic        m_have, m_port_d, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdval;
    int          m_g, m_free, m_starve;
    logic [31:0] e_addr, e_irdata, e_drdata;

    always @(negedge clk) begin : cmp
        logic       e_igt, e_dgt, e_irv, e_drv, e_mw;
        logic [3:0] e_be;
        int         fin;
        if (!ref_loaded) begin
            for (int i = 0; i < 256; i++) refm[i] = 32'h0;
            refm[65]   = 32'hDEAD_BEEF;
            refm[128]  = 32'hAABB_CCDD;
            ref_loaded = 1'b1;
        end
        if (!rst_n) begin
            m_have = 1'b0; m_free = 0; m_starve = 0;
            e_addr = 32'h0; e_irdata = 32'h0; e_drdata = 32'h0;
            check("rst_ctl", {23'd0, i_gnt0, d_gnt0, i_rvalid0, d_rvalid0, mem_wr0, mem_be0}, 32'h0);
            check("rst_i_rdata", i_rdata0, 32'h0);
            check("rst_d_rdata", d_rdata0, 32'h0);
            check("rst_mem_addr", mem_addr0, 32'h0);
            check("rst_mem_wdata", mem_wd0, 32'h0);
        end else begin
            e_irv = 1'b0; e_drv = 1'b0; e_mw = 1'b0; e_be = 4'h0;
            if (m_have) begin
                fin = m_g + 1 + W0;
                if (cyc == m_g + 1) e_addr = m_addr;
                if (cyc >= m_g + 1 && cyc <= fin) e_be = m_be;
                if (cyc == fin) begin
                    e_mw = m_we;
                    if (m_we) begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[b]) refm[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
                    end else begin
                        m_rdval = refm[m_addr[9:2]];
                    end
                end
                if (cyc == fin + 1) begin
                    if (m_port_d) begin
                        e_drv = 1'b1;
                        if (!m_we) e_drdata = m_rdval;
                    end else begin
                        e_irv    = 1'b1;
                        e_irdata = m_rdval;
                    end
                end
            end
            e_igt = 1'b0; e_dgt = 1'b0;
            if (cyc >= m_free) begin
                if (i_req0 && d_req0) begin
                    if (m_starve == SMAX) e_igt = 1'b1;
                    else                  e_dgt = 1'b1;
                end else begin
                    e_igt = i_req0;
                    e_dgt = d_req0;
                end
            end
            if (e_igt || e_dgt) begin
                if (e_igt)                         m_starve = 0;
                else if (i_req0 && m_starve < SMAX) m_starve = m_starve + 1;
                m_have   = 1'b1;
                m_g      = cyc;
                m_free   = cyc + 2 + W0;
                m_port_d = e_dgt;
                m_we     = e_dgt && d_we;
                m_be     = (e_dgt && d_we) ? d_be : 4'hF;
                m_addr   = e_dgt ? d_addr : {i_addr[31:2], 2'b00};
                m_wdata  = d_wdata;
            end
            check("i_gnt", {31'd0, i_gnt0}, {31'd0, e_igt});
            check("d_gnt", {31'd0, d_gnt0}, {31'd0, e_dgt});
            check("i_rvalid", {31'd0, i_rvalid0}, {31'd0, e_irv});
            check("d_rvalid", {31'd0, d_rvalid0}, {31'd0, e_drv});
            check("i_rdata", i_rdata0, e_irdata);
            check("d_rdata", d_rdata0, e_drdata);
            check("mem_address", mem_addr0, e_addr);
            check("mem_write", {31'd0, mem_wr0}, {31'd0, e_mw});
            check("mem_byte_en", {28'd0, mem_be0}, {28'd0, e_be});
            if (e_mw) check("mem_writedata", mem_wd0, m_wdata);
        end
    end

    // Raise a request on instance 0, wait (bounded) for its grant, then drop it.
    task automatic issue(input bit is_d, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd, output int gc);
        @(posedge clk); #1;
        if (is_d) begin
            d_req0 = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd;
        end else begin
            i_req0 = 1'b1; i_addr = addr;
        end
        gc = -1;
        for (int k = 0; k < 20 && gc < 0; k++) begin
            @(negedge clk);
            if (is_d ? d_gnt0 : i_gnt0) gc = cyc;
        end
        total++;
        if (gc < 0) begin
            bad++;
            $display("FAIL grant_timeout: got no grant expected grant within 20 cycles");
        end
        @(posedge clk); #1;
        i_req0 = 1'b0; d_req0 = 1'b0;
    endtask

    initial begin
        int    gc, g1, g2, r1, wp, ng;
        logic [31:0] rd;
        string seq;
        rst_n = 1'b1;
        i_req0 = 0; d_req0 = 0; i_req3 = 0; d_req3 = 0;
        d_we = 0; d_be = 4'h0; i_addr = 0; d_addr = 0; d_wdata = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // idle: no requests, nothing on the memory port
        repeat (20) @(negedge clk);
        check("idle_no_write", wr_pulses0, 32'd0);
        check("idle_outputs", {23'd0, i_gnt0, d_gnt0, i_rvalid0, d_rvalid0, mem_wr0, mem_be0}, 32'h0);

        // instruction fetch from an unaligned address
        issue(1'b0, 1'b0, 4'h0, 32'h0000_0106, 32'h0, gc);
        @(negedge clk);
        check("fetch_addr", mem_addr0, 32'h0000_0104);
        @(negedge clk);
        check("fetch_rvalid", {31'd0, i_rvalid0}, 32'd1);
        check("fetch_rdata", i_rdata0, 32'hDEAD_BEEF);

        // byte-enabled write then read back
        wp = wr_pulses0;
        issue(1'b1, 1'b1, 4'b0101, 32'h0000_0200, 32'h1122_3344, gc);
        repeat (4) @(negedge clk);
        check("write_pulses", wr_pulses0 - wp, 32'd1);
        issue(1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0, gc);
        @(negedge clk);
        @(negedge clk);
        check("readback_rvalid", {31'd0, d_rvalid0}, 32'd1);
        check("readback_rdata", d_rdata0, 32'hAA22_CC44);

        // both ports held: data wins STARVE_MAX times, then fetch
        @(posedge clk); #1;
        i_addr = 32'h104; d_addr = 32'h200; d_we = 1'b0;
        i_req0 = 1'b1; d_req0 = 1'b1;
        seq = ""; ng = 0;
        for (int k = 0; k < 40 && ng < 10; k++) begin
            @(negedge clk);
            if (i_gnt0) begin seq = {seq, "I"}; ng++; end
            if (d_gnt0) begin seq = {seq, "D"}; ng++; end
        end
        @(posedge clk); #1;
        i_req0 = 1'b0; d_req0 = 1'b0;
        total++;
        if (seq != "DDDDIDDDDI") begin
            bad++;
            $display("FAIL grant_order: got %s expected DDDDIDDDDI", seq);
        end
        repeat (4) @(posedge clk);

        // WAIT_CYCLES=3 instance: rvalid 5 cycles after grant, regrant in RESP cycle
        #1;
        d_we = 1'b0; d_addr = 32'h300; d_req3 = 1'b1;
        g1 = -1; g2 = -1; r1 = -1; rd = 32'h0;
        for (int k = 0; k < 40 && g2 < 0; k++) begin
            @(negedge clk);
            if (d_gnt3) begin
                if (g1 < 0) g1 = cyc;
                else        g2 = cyc;
            end
            if (d_rvalid3 && r1 < 0) begin
                r1 = cyc;
                rd = d_rdata3;
            end
        end
        @(posedge clk); #1;
        d_req3 = 1'b0;
        check("w3_latency", r1 - g1, 32'd5);
        check("w3_rdata", rd, 32'h1234_5678);
        check("w3_resp_grant", g2, r1);
        repeat (8) @(posedge clk);

        // reset during the final BUSY cycle of a write
        #1;
        d_req0 = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'hFFFF_FFFF;
        gc = -1;
        for (int k = 0; k < 20 && gc < 0; k++) begin
            @(negedge clk);
            if (d_gnt0) gc = cyc;
        end
        total++;
        if (gc < 0) begin
            bad++;
            $display("FAIL rst_write_grant: got no grant expected grant within 20 cycles");
        end
        @(posedge clk); #1;
        d_req0 = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check("rst_kill_write", {31'd0, mem_wr0}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        check("rst_mem_unchanged", mem0[128], 32'hAA22_CC44);
        #1 i_req0 = 1'b1; i_addr = 32'h104;
        @(negedge clk);
        check("idle_after_rst", {31'd0, i_gnt0}, 32'd1);
        @(posedge clk); #1;
        i_req0 = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
